memory_page_burst_ctrl: RTL

Burst access controller sitting directly upstream of `memory_page`. It accepts write or read burst commands over a valid/ready handshake and sequences them into per-beat `in`/`addr`/`en_i` drive toward the memory page. Read data captured from the page's registered `out` is returned as a data stream with a last-beat marker. Bursts use incrementing addresses that wrap modulo 2^ADDR_WIDTH.

---
 rtl/memory_page_pkg.sv | 22 ++
 rtl/memory_page_addr_gen.sv | 58 +++++
 rtl/memory_page_burst_ctrl.sv | 108 ++++++++++
 3 files changed

// File: rtl/memory_page_pkg.sv
// Shared types, default widths and address helper for the memory_page burst controller.
package memory_page_pkg;

  localparam int MP_ELEM_WIDTH = 8;
  localparam int MP_ADDR_WIDTH = 13;
  localparam int MP_LEN_WIDTH  = 4;

  typedef enum logic [1:0] {
    MP_IDLE  = 2'd0,
    MP_WRITE = 2'd1,
    MP_READ  = 2'd2,
    MP_DRAIN = 2'd3
  } mp_state_e;

  // Incrementing page address; rolls over from all-ones to zero with no flag.
  function automatic logic [MP_ADDR_WIDTH-1:0] mp_next_addr(
    input logic [MP_ADDR_WIDTH-1:0] addr
  );
    return addr + MP_ADDR_WIDTH'(1);
  endfunction

endpackage

// File: rtl/memory_page_addr_gen.sv
// Burst address generator: loads start address and beat count, then steps
// the address forward and counts beats down, flagging the final beat.
module memory_page_addr_gen
  import memory_page_pkg::*;
#(
  parameter int ADDR_WIDTH = MP_ADDR_WIDTH,
  parameter int LEN_WIDTH  = MP_LEN_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic                  step_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  last_o
);

  logic [ADDR_WIDTH-1:0] addr_q, addr_d, addr_inc;
  logic [LEN_WIDTH-1:0]  beats_q, beats_d;

  // Wrap increment; the shared helper is only usable at the default width.
  if (ADDR_WIDTH == MP_ADDR_WIDTH) begin : g_pkg_inc
    assign addr_inc = mp_next_addr(addr_q);
  end else begin : g_local_inc
    assign addr_inc = addr_q + ADDR_WIDTH'(1);
  end

  // Next address / remaining-beat selection: load wins over step.
  always_comb begin
    // NOTE: every variable gets a default first so no latch is inferred.
    addr_d  = addr_q;
    beats_d = beats_q;
    if (load_i) begin
      addr_d  = addr_i;
      beats_d = len_i;
    end else if (step_i) begin
      addr_d  = addr_inc;
      beats_d = beats_q - LEN_WIDTH'(1);
    end
  end

  // Counter registers with synchronous clear.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) begin
      addr_q  <= '0;
      beats_q <= '0;
    end else begin
      addr_q  <= addr_d;
      beats_q <= beats_d;
    end
  end

  assign addr_o = addr_q;
  assign last_o = (beats_q == '0);

endmodule

// File: rtl/memory_page_burst_ctrl.sv
// Burst controller in front of memory_page: accepts write/read burst
// commands, drives per-beat page accesses and returns read data with a
// last-beat marker aligned to the page's one-cycle read latency.
module memory_page_burst_ctrl
  import memory_page_pkg::*;
#(
  parameter int ELEM_WIDTH = MP_ELEM_WIDTH,
  parameter int ADDR_WIDTH = MP_ADDR_WIDTH,
  parameter int LEN_WIDTH  = MP_LEN_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [LEN_WIDTH-1:0]  cmd_len_i,
  input  logic                  wdata_valid_i,
  output logic                  wdata_ready_o,
  input  logic [ELEM_WIDTH-1:0] wdata_i,
  output logic                  rdata_valid_o,
  output logic [ELEM_WIDTH-1:0] rdata_o,
  output logic                  rdata_last_o,
  output logic                  busy_o,
  output logic [ELEM_WIDTH-1:0] mp_in_o,
  output logic [ADDR_WIDTH-1:0] mp_addr_o,
  output logic                  mp_en_o,
  input  logic [ELEM_WIDTH-1:0] mp_out_i
);

  mp_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ADDR_WIDTH-1:0] mp_addr_q;
  logic [ELEM_WIDTH-1:0] mp_in_q;
  logic                  last_beat;
  logic                  cmd_fire, wr_fire, rd_issue, step;
  logic                  issue_q, issue_d;
  logic                  rlast_q, rlast_d;

  // Handshakes are suppressed during reset so an in-flight burst cannot
  // fire a page write or issue while it is being aborted.
  assign cmd_ready_o   = (state_q == MP_IDLE)  && !rst_i;
  assign wdata_ready_o = (state_q == MP_WRITE) && !rst_i;
  assign cmd_fire      = cmd_valid_i && cmd_ready_o;
  assign wr_fire       = wdata_valid_i && wdata_ready_o;
  assign rd_issue      = (state_q == MP_READ) && !rst_i;
  assign step          = wr_fire || rd_issue;
  assign busy_o        = (state_q != MP_IDLE);

  memory_page_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH)
  ) u_addr_gen (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (cmd_fire),
    .step_i (step),
    .addr_i (cmd_addr_i),
    .len_i  (cmd_len_i),
    .addr_o (cur_addr),
    .last_o (last_beat)
  );

  // Burst sequencing: a write leaves on its last accepted beat, a read
  // leaves for DRAIN on its last issue so the final data beat can return.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MP_IDLE:  if (cmd_fire) state_d = cmd_write_i ? MP_WRITE : MP_READ;
      MP_WRITE: if (wr_fire && last_beat) state_d = MP_IDLE;
      MP_READ:  if (last_beat) state_d = MP_DRAIN;
      MP_DRAIN: state_d = MP_IDLE;
      default:  state_d = MP_IDLE;
    endcase
  end

  // Page drive: live values on an active beat, otherwise the last ones driven.
  always_comb begin
    mp_en_o   = wr_fire;
    mp_in_o   = wr_fire ? wdata_i : mp_in_q;
    mp_addr_o = step ? cur_addr : mp_addr_q;
    issue_d   = rd_issue;
    rlast_d   = rd_issue && last_beat;
  end

  // State, held page drive and the one-cycle read-return pipeline.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= MP_IDLE;
      mp_addr_q <= '0;
      mp_in_q   <= '0;
      issue_q   <= 1'b0;
      rlast_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      mp_addr_q <= mp_addr_o;
      mp_in_q   <= mp_in_o;
      issue_q   <= issue_d;
      rlast_q   <= rlast_d;
    end
  end

  // Page output is already registered, so read data passes straight through.
  assign rdata_valid_o = issue_q;
  assign rdata_last_o  = rlast_q;
  assign rdata_o       = mp_out_i;

endmodule
